// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage MIPS pipeline: load-use/RAW stalls,
// branch flush, MEM-stage SRAM freeze handshake, wait watchdog and stall counter.
module hazard_stall_ctrl #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             fwd_en,
   input  logic [4:0]       id_src1,
   input  logic [4:0]       id_src2,
   input  logic             id_uses_src2,
   input  logic [4:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [4:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             mem_r_en,
   input  logic             mem_w_en,
   input  logic             branch_taken,
   input  logic             sram_ready,
   output logic             hazard_stall,
   output logic             bubble,
   output logic             flush,
   output logic             freeze_all,
   output logic             mem_req,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam logic [0:0] RUN      = 1'b0;
   localparam logic [0:0] MEM_WAIT = 1'b1;

   localparam int unsigned        WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0]  WAIT_MAX  = WAIT_W'(TIMEOUT);
   localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   logic [0:0]        state, state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              timeout_q;
   logic [CNT_W-1:0]  cnt_q;

   logic mem_access;
   logic exe_hit, mem_hit, raw;

   always_comb begin
      mem_access = mem_r_en | mem_w_en;
      exe_hit = exe_wb_en && (exe_dest != 5'd0) &&
                ((exe_dest == id_src1) || (id_uses_src2 && (exe_dest == id_src2)));
      mem_hit = mem_wb_en && (mem_dest != 5'd0) &&
                ((mem_dest == id_src1) || (id_uses_src2 && (mem_dest == id_src2)));
      raw = fwd_en ? (exe_mem_r_en & exe_hit) : (exe_hit | mem_hit);
   end

   // Every decision output is forced low while rst is held, so a reset
   // during MEM_WAIT drops the request in the same cycle.
   always_comb begin
      state_nxt  = state;
      freeze_all = 1'b0;
      mem_req    = 1'b0;
      case (state)
         RUN: begin
            if (mem_access) begin
               freeze_all = 1'b1;
               mem_req    = 1'b1;
               state_nxt  = MEM_WAIT;
            end
         end
         default: begin
            mem_req    = 1'b1;
            freeze_all = ~sram_ready;
            if (sram_ready)
               state_nxt = RUN;
         end
      endcase
      if (rst) begin
         freeze_all = 1'b0;
         mem_req    = 1'b0;
      end
      flush        = ~rst & branch_taken & ~freeze_all;
      hazard_stall = ~rst & raw & ~freeze_all & ~branch_taken;
      bubble       = hazard_stall;
      mem_timeout  = ~rst & timeout_q;
      stall_cycles = rst ? '0 : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state <= state_nxt;
         if (state == RUN)
            wait_cnt <= '0;
         else if (!sram_ready && (wait_cnt != WAIT_MAX))
            wait_cnt <= wait_cnt + WAIT_W'(1);
         if ((state == MEM_WAIT) && !sram_ready && (wait_cnt == WAIT_LAST))
            timeout_q <= 1'b1;
         if ((freeze_all || hazard_stall) && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl: combinational vector table
// plus hand-written multi-cycle sequences on a default and a small-parameter instance.
module tb_hazard_stall_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       fwd_en, id_uses_src2, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic       mem_r_en, mem_w_en, branch_taken, sram_ready;
   logic [4:0] id_src1, id_src2, exe_dest, mem_dest;

   logic        hazard_stall, bubble, flush, freeze_all, mem_req, mem_timeout;
   logic [15:0] stall_cycles;
   logic        hazard_stall_s, bubble_s, flush_s, freeze_all_s, mem_req_s, mem_timeout_s;
   logic [3:0]  stall_cycles_s;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl dut (
      .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
      .id_uses_src2(id_uses_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .branch_taken(branch_taken),
      .sram_ready(sram_ready), .hazard_stall(hazard_stall), .bubble(bubble),
      .flush(flush), .freeze_all(freeze_all), .mem_req(mem_req),
      .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
   );

   hazard_stall_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_src1(id_src1), .id_src2(id_src2),
      .id_uses_src2(id_uses_src2), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .branch_taken(branch_taken),
      .sram_ready(sram_ready), .hazard_stall(hazard_stall_s), .bubble(bubble_s),
      .flush(flush_s), .freeze_all(freeze_all_s), .mem_req(mem_req_s),
      .mem_timeout(mem_timeout_s), .stall_cycles(stall_cycles_s)
   );

   typedef struct {
      logic       fwd;
      logic [4:0] s1;
      logic [4:0] s2;
      logic       us2;
      logic [4:0] ed;
      logic       ewb;
      logic       er;
      logic [4:0] md;
      logic       mwb;
      logic       br;
      logic       e_stall;
      logic       e_flush;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic clr_in();
      fwd_en = 1'b1; id_src1 = '0; id_src2 = '0; id_uses_src2 = 1'b0;
      exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
      mem_dest = '0; mem_wb_en = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
      branch_taken = 1'b0; sram_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr_in();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_use();
      fwd_en = 1'b1; exe_mem_r_en = 1'b1; exe_wb_en = 1'b1; exe_dest = 5'd5; id_src1 = 5'd5;
   endtask

   initial begin
      rst = 1'b1;
      clr_in();

      //                fwd s1  s2  us2 ed  ewb er  md  mwb br  stall flush
      vecs[0]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{1'b1, 5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 5'd1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 5'd1, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[13] = '{1'b1, 5'd2, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state, with a load-use hazard and a branch present on the inputs
      @(negedge clk);
      load_use(); branch_taken = 1'b1; mem_r_en = 1'b1;
      #2;
      chk("rst_stall", hazard_stall, 0);
      chk("rst_flush", flush, 0);
      chk("rst_freeze", freeze_all, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_cnt", stall_cycles, 0);
      chk("rst_timeout", mem_timeout, 0);
      @(negedge clk);
      clr_in(); rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         clr_in();
         fwd_en = vecs[i].fwd; id_src1 = vecs[i].s1; id_src2 = vecs[i].s2;
         id_uses_src2 = vecs[i].us2; exe_dest = vecs[i].ed; exe_wb_en = vecs[i].ewb;
         exe_mem_r_en = vecs[i].er; mem_dest = vecs[i].md; mem_wb_en = vecs[i].mwb;
         branch_taken = vecs[i].br;
         #2;
         chk($sformatf("vec%0d_stall", i), hazard_stall, vecs[i].e_stall);
         chk($sformatf("vec%0d_bubble", i), bubble, vecs[i].e_stall);
         chk($sformatf("vec%0d_flush", i), flush, vecs[i].e_flush);
         chk($sformatf("vec%0d_freeze", i), freeze_all, 0);
         chk($sformatf("vec%0d_req", i), mem_req, 0);
      end

      // Load-use: one bubble, then the load has moved to MEM and forwarding covers it
      do_reset();
      @(negedge clk); clr_in(); load_use(); #2;
      chk("lu_stall", hazard_stall, 1);
      chk("lu_bubble", bubble, 1);
      chk("lu_cnt0", stall_cycles, 0);
      @(negedge clk); clr_in(); id_src1 = 5'd5; mem_dest = 5'd5; mem_wb_en = 1'b1; #2;
      chk("lu_stall_next", hazard_stall, 0);
      chk("lu_cnt1", stall_cycles, 1);

      // No forwarding: ALU writer of r3 in EXE, then in MEM, then gone
      do_reset();
      @(negedge clk); clr_in(); fwd_en = 1'b0; id_src1 = 5'd3; exe_dest = 5'd3; exe_wb_en = 1'b1; #2;
      chk("nf_c0", hazard_stall, 1);
      @(negedge clk); clr_in(); fwd_en = 1'b0; id_src1 = 5'd3; mem_dest = 5'd3; mem_wb_en = 1'b1; #2;
      chk("nf_c1", hazard_stall, 1);
      @(negedge clk); clr_in(); fwd_en = 1'b0; id_src1 = 5'd3; #2;
      chk("nf_c2", hazard_stall, 0);
      chk("nf_cnt", stall_cycles, 2);

      // Store, ready on the 4th MEM_WAIT cycle
      do_reset();
      for (int c = 0; c < 6; c++) begin
         @(negedge clk); clr_in();
         mem_w_en = (c <= 4); sram_ready = (c == 4);
         #2;
         chk($sformatf("st_freeze_c%0d", c), freeze_all, (c < 4));
         chk($sformatf("st_req_c%0d", c), mem_req, (c <= 4));
      end
      chk("st_cnt", stall_cycles, 4);

      // Back-to-back loads with sram_ready held high (ignored in RUN)
      do_reset();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); clr_in();
         mem_r_en = (c < 4); sram_ready = 1'b1;
         #2;
         chk($sformatf("b2b_freeze_c%0d", c), freeze_all, (c == 0 || c == 2));
         chk($sformatf("b2b_req_c%0d", c), mem_req, (c < 4));
      end
      chk("b2b_cnt", stall_cycles, 2);

      // Branch plus load-use while frozen: flush only once the freeze releases
      do_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk); clr_in();
         if (c < 3) begin
            load_use(); branch_taken = 1'b1; mem_w_en = 1'b1;
         end
         sram_ready = (c == 2);
         #2;
         chk($sformatf("brf_flush_c%0d", c), flush, (c == 2));
         chk($sformatf("brf_bubble_c%0d", c), bubble, 0);
         chk($sformatf("brf_freeze_c%0d", c), freeze_all, (c < 2));
      end

      // Watchdog and counter saturation: 20 freeze cycles, then release
      do_reset();
      for (int c = 0; c < 21; c++) begin
         @(negedge clk); clr_in();
         mem_r_en = 1'b1; sram_ready = (c == 20);
         #2;
         chk($sformatf("wd_freeze_c%0d", c), freeze_all_s, (c < 20));
         chk($sformatf("wd_timeout_s_c%0d", c), mem_timeout_s, (c >= 9));
      end
      @(negedge clk); clr_in(); #2;
      chk("wd_timeout_sticky", mem_timeout_s, 1);
      chk("wd_timeout_default", mem_timeout, 0);
      chk("wd_cnt_sat", stall_cycles_s, 15);
      chk("wd_cnt_default", stall_cycles, 20);
      @(negedge clk); clr_in(); #2;
      chk("wd_timeout_sticky2", mem_timeout_s, 1);

      // Reset in the middle of a wait
      @(negedge clk); clr_in(); mem_r_en = 1'b1;
      @(negedge clk); clr_in(); mem_r_en = 1'b1; #2;
      chk("mr_freeze_wait", freeze_all, 1);
      @(negedge clk); clr_in(); mem_r_en = 1'b1; load_use(); branch_taken = 1'b1; rst = 1'b1; #2;
      chk("mr_req", mem_req, 0);
      chk("mr_freeze", freeze_all, 0);
      chk("mr_flush", flush, 0);
      chk("mr_stall", hazard_stall, 0);
      chk("mr_timeout_s", mem_timeout_s, 0);
      chk("mr_cnt", stall_cycles, 0);
      @(negedge clk); clr_in(); rst = 1'b0; mem_r_en = 1'b1; sram_ready = 1'b1; #2;
      chk("mr_run_freeze", freeze_all, 1);
      chk("mr_run_timeout_s", mem_timeout_s, 0);
      chk("mr_run_cnt_s", stall_cycles_s, 0);
      @(negedge clk); clr_in(); mem_r_en = 1'b1; sram_ready = 1'b1; #2;
      chk("mr_wait_release", freeze_all, 0);

      @(negedge clk); clr_in();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall sequencer for the 5-stage MIPS core, working alongside the forwarding unit. Each cycle it decides whether the front end holds, inserts a bubble into ID/EXE, flushes IF/ID on a taken branch, or freezes the whole pipeline while the MEM-stage SRAM access completes. It owns the SRAM request handshake, a wait-timeout watchdog and a saturating stall-cycle counter.

## Interface
- `TIMEOUT`, 255: max MEM_WAIT cycles before `mem_timeout` is raised.
- `CNT_W`, 16: width of `stall_cycles`.

- `clk`  in  1  clock; rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fwd_en`  in  1  1 = forwarding active; 0 = resolve every RAW hazard by stalling.
- `id_src1`  in  5  ID-stage source register 1.
- `id_src2`  in  5  ID-stage source register 2 (or store-data source).
- `id_uses_src2`  in  1  ID instruction reads `id_src2`.
- `exe_dest`  in  5  EXE-stage destination.
- `exe_wb_en`  in  1  EXE-stage write-back enable.
- `exe_mem_r_en`  in  1  EXE-stage instruction is a load.
- `mem_dest`  in  5  MEM-stage destination.
- `mem_wb_en`  in  1  MEM-stage write-back enable.
- `mem_r_en`, `mem_w_en`  in  1 each  MEM-stage load / store.
- `branch_taken`  in  1  EXE-stage branch resolved taken.
- `sram_ready`  in  1  SRAM completes the current access.
- `hazard_stall`  out  1  hold PC and IF/ID.
- `bubble`  out  1  load NOP into ID/EXE.
- `flush`  out  1  clear IF/ID.
- `freeze_all`  out  1  hold every pipeline register.
- `mem_req`  out  1  SRAM access request.
- `mem_timeout`  out  1  sticky watchdog flag.
- `stall_cycles`  out  CNT_W  saturating count of stalled cycles.

## Operation
- Register 0 never causes a hazard. A match needs a nonzero dest and the matching wb_en.
- `mem_access = mem_r_en | mem_w_en`.
- Raw hazard `raw`:
  - `fwd_en=1`: `exe_mem_r_en & exe_wb_en & exe_dest!=0 & (exe_dest==id_src1 | (id_uses_src2 & exe_dest==id_src2))`. This is load-use only.
  - `fwd_en=0`: the same match test against EXE (any wb_en) OR against MEM.
- FSM states: RUN, MEM_WAIT. Reset state is RUN.
- RUN:
  - If `mem_access`: `mem_req=1`, `freeze_all=1`, next state MEM_WAIT. `sram_ready` is ignored in RUN, so every access costs at least one freeze cycle.
  - Otherwise: `freeze_all=0`, stay in RUN.
- MEM_WAIT:
  - `mem_req=1`, `freeze_all=~sram_ready`.
  - On `sram_ready=1`, the pipeline advances this cycle and next state is RUN.
  - Otherwise a wait counter increments. When it reaches `TIMEOUT`, `mem_timeout` sets (sticky until `rst`) and the FSM stays in MEM_WAIT.
  - The wait counter clears on entry to MEM_WAIT.
- Masking:
  - `hazard_stall = bubble = raw & ~freeze_all`.
  - `flush = branch_taken & ~freeze_all`.
  - `flush` has priority over `raw`: if both are set, `flush=1` and `hazard_stall=bubble=0`, because the ID instruction is discarded.
- `stall_cycles` increments on any cycle where `freeze_all | hazard_stall`. It saturates at all-ones and does not wrap.

## Timing
- All decision outputs are combinational from the current inputs and state. The state, wait counter, `mem_timeout` and `stall_cycles` update on the rising edge of `clk`.
- While `rst=1`, every output is 0. On the next edge the state is RUN and the counters and flag are 0. Reset asserted in MEM_WAIT aborts the wait and drops `mem_req` immediately.
- A load-use hazard produces exactly one bubble cycle: the next cycle the load reaches MEM and `raw` clears under `fwd_en=1`.
- With `fwd_en=0`, a dependency on EXE stalls 2 cycles and a dependency on MEM stalls 1 cycle (no memory waits).
- A memory access with `sram_ready` arriving on the Nth MEM_WAIT cycle freezes for N cycles (1 in RUN + N−1 in MEM_WAIT). `mem_req` is high for N+1 cycles.
- If `mem_access` is still high on the cycle after release, a new request starts immediately (back-to-back accesses).

## Test plan
- Load-use, `fwd_en=1`: `exe_mem_r_en=1`, `exe_wb_en=1`, `exe_dest=5`, `id_src1=5` → `hazard_stall=bubble=1` for 1 cycle, `stall_cycles`=1. Repeat with `exe_dest=0` → no stall.
- `fwd_en=0`, ALU op writes r3 followed by a reader of r3 → 2 stall cycles. `id_uses_src2=0` with the match only on src2 → no stall.
- Store in MEM, `sram_ready` high on the 4th MEM_WAIT cycle → `freeze_all` high 4 cycles, `mem_req` high 5 cycles, state returns to RUN, `stall_cycles`=4.
- `branch_taken` together with a load-use hazard → `flush=1`, `bubble=0`. The same with MEM_WAIT active → `flush=0` until the freeze releases.
- `TIMEOUT=8`, `sram_ready` held low → `mem_timeout` rises after 8 MEM_WAIT cycles and stays high after a later `sram_ready`. Only `rst` clears it.
- `CNT_W=4`, 20 continuous freeze cycles → `stall_cycles`=15 (saturated). `rst` mid-wait → all outputs 0 and RUN on the next edge.
